// File: rtl/hyperbus_rx_packer.sv
// hyperbus_rx_packer: packs W-bit PHY read words (W = 16*NumPhys) into
// AxiDataWidth-bit beats for the AXI R path. It uses a single output
// register, and a completing word may enter in the same cycle the held
// beat drains, so throughput is full.
// Optional feature: define HYPERBUS_RX_PACKER_STATS_EN to add saturating
// beat/error counters (beat_cnt_o, err_cnt_o).
module hyperbus_rx_packer #(
    parameter int NumPhys      = 2,
    parameter int AxiDataWidth = 128
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         clear_i,
    input  logic [16*NumPhys-1:0]                        rx_data_i,
    input  logic                                         rx_last_i,
    input  logic                                         rx_error_i,
    input  logic                                         rx_valid_i,
    output logic                                         rx_ready_o,
    output logic [AxiDataWidth-1:0]                      data_o,
    output logic [$clog2(AxiDataWidth/(16*NumPhys)):0]   words_o,
    output logic                                         last_o,
    output logic                                         error_o,
`ifdef HYPERBUS_RX_PACKER_STATS_EN
    output logic [31:0]                                  beat_cnt_o,
    output logic [15:0]                                  err_cnt_o,
`endif
    output logic                                         valid_o,
    input  logic                                         ready_i
);

    localparam int W      = 16 * NumPhys;
    localparam int R      = AxiDataWidth / W;
    localparam int IdxW   = (R > 1) ? $clog2(R) : 1;
    localparam int WordsW = $clog2(R) + 1;

    // Reject geometries where a beat is not a power-of-two count of words.
    if ((AxiDataWidth % W) != 0 || R < 1 || (R & (R - 1)) != 0) begin : g_bad_cfg
        $error("hyperbus_rx_packer: AxiDataWidth/(16*NumPhys) must be a power of two >= 1");
    end

    logic [IdxW-1:0]         wr_idx;
    logic [AxiDataWidth-1:0] acc_data;
    logic                    acc_err;
    logic [AxiDataWidth-1:0] beat_data;
    logic                    completes;
    logic                    rx_fire;
    logic                    out_fire;

    // The word about to be offered closes the beat if it fills the last lane
    // or carries the burst's last flag.
    assign completes = (wr_idx == IdxW'(R - 1)) || rx_last_i;

    // Back-pressure only when a completing word has nowhere to go: the output
    // register is full and is not draining this cycle.
    assign rx_ready_o = !(completes && valid_o && !ready_i);

    // clear_i drops any input transfer in its cycle.
    assign rx_fire  = rx_valid_i && rx_ready_o && !clear_i;
    assign out_fire = valid_o && ready_i;

    // Merge the incoming word into its lane of the accumulator.
    // NOTE: always_comb assigns every output first, so no latch can form.
    always_comb begin
        beat_data = acc_data;
        beat_data[wr_idx*W +: W] = rx_data_i;
    end

    // Accumulator: collects words until a beat completes, then restarts at
    // lane 0 zeroed, which is what leaves unused lanes of a partial beat at 0.
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the accumulator is a plain register bank, not a RAM, so it
            // is reset like any other state; a partial beat must not survive reset.
            wr_idx   <= '0;
            acc_data <= '0;
            acc_err  <= 1'b0;
        end else if (clear_i) begin
            wr_idx   <= '0;
            acc_data <= '0;
            acc_err  <= 1'b0;
        end else if (rx_fire) begin
            if (completes) begin
                wr_idx   <= '0;
                acc_data <= '0;
                acc_err  <= 1'b0;
            end else begin
                wr_idx   <= wr_idx + IdxW'(1);
                acc_data <= beat_data;
                acc_err  <= acc_err | rx_error_i;
            end
        end
    end

    // Output register: loads a completed beat (possibly while draining the
    // previous one) and otherwise empties when the consumer takes the beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            words_o <= '0;
            last_o  <= 1'b0;
            error_o <= 1'b0;
        end else if (rx_fire && completes) begin
            valid_o <= 1'b1;
            data_o  <= beat_data;
            words_o <= WordsW'(wr_idx) + WordsW'(1);
            last_o  <= rx_last_i;
            error_o <= acc_err | rx_error_i;
        end else if (out_fire) begin
            valid_o <= 1'b0;
        end
    end

`ifdef HYPERBUS_RX_PACKER_STATS_EN
    // Saturating counters of transferred beats and of erroneous beats;
    // clear_i deliberately has no effect on them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_cnt_o <= '0;
            err_cnt_o  <= '0;
        end else if (out_fire) begin
            if (beat_cnt_o != '1) begin
                beat_cnt_o <= beat_cnt_o + 32'd1;
            end
            if (error_o && err_cnt_o != '1) begin
                err_cnt_o <= err_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/hyperbus_rx_packer.md
HYPERBUS_RX_PACKER -- requirements
Module: hyperbus_rx_packer

Interface
REQ-001 SHALL have parameter NumPhys, default 2, number of PHYs; input word width W = 16*NumPhys.
REQ-002 SHALL have parameter AxiDataWidth, default 128, output beat width; R = AxiDataWidth/W, where R is a power of two and at least 1 (elaboration error otherwise).
REQ-003 SHALL have port clk_i, input, 1, sole clock; all logic is rising-edge.
REQ-004 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port clear_i, input, 1, synchronous discard of the partial beat.
REQ-006 SHALL have port rx_data_i, input, W, PHY-side read word from the RX CDC FIFO.
REQ-007 SHALL have ports rx_last_i and rx_error_i, each input, 1, marking the last word of the burst and an erroneous word.
REQ-008 SHALL have ports rx_valid_i (input, 1) and rx_ready_o (output, 1), the input handshake.
REQ-009 SHALL have port data_o, output, AxiDataWidth, packed beat.
REQ-010 SHALL have port words_o, output, clog2(R)+1, number of valid words in the beat, 1..R.
REQ-011 SHALL have ports last_o and error_o, each output, 1, beat attributes.
REQ-012 SHALL have ports valid_o (output, 1) and ready_i (input, 1), the output handshake towards the AXI R path.

Function
REQ-013 SHALL transfer an input word when rx_valid_i and rx_ready_o are both high in the same cycle, and transfer a beat when valid_o and ready_i are both high in the same cycle.
REQ-014 SHALL write the accepted word k of a beat into accumulator bits [k*W +: W], where k is a write index counting 0..R-1.
REQ-015 SHALL complete a beat when the word at index R-1, or any word with rx_last_i high, is accepted.
REQ-016 SHALL hold a completed beat in a single output register, asserting valid_o from the cycle after the completing word is accepted (latency 1).
REQ-017 SHALL zero the data lanes above the last written word in a partial beat, and set words_o to k+1.
REQ-018 SHALL set error_o to the OR of rx_error_i over all words of the beat, and last_o to the rx_last_i value of the completing word.
REQ-019 SHALL drive rx_ready_o low only when the next word would complete a beat while the output register is full and ready_i is low; otherwise rx_ready_o is high.
REQ-020 SHALL allow a completing word to be accepted in the same cycle the output register drains, giving full throughput with no bubble.
REQ-021 SHALL wrap the write index to 0 after a beat completes, and reset the accumulator error flag at the same point.
REQ-022 SHALL, when R = 1, forward each word as its own beat through the output register with words_o = 1.
REQ-023 SHALL, on clear_i, zero the write index and accumulator and drop an input transfer in the same cycle, while keeping a beat already in the output register.
REQ-024 SHALL keep data_o, words_o, last_o and error_o stable while valid_o is high and ready_i is low.

Reset
REQ-025 SHALL, while rst_i is high, force valid_o, data_o, words_o, last_o and error_o to 0, the write index and accumulator to 0, and rx_ready_o to 1.
REQ-026 SHALL, when reset asserts mid-beat, discard the partial beat and any held output beat, with no beat presented after release.

Configuration
REQ-027 SHALL, when macro HYPERBUS_RX_PACKER_STATS_EN is defined, add outputs beat_cnt_o (32 bits, counting transferred beats) and err_cnt_o (16 bits, counting beats with error_o high), both saturating at all-ones, reset to 0 and unaffected by clear_i.
REQ-028 SHALL, when HYPERBUS_RX_PACKER_STATS_EN is undefined, not have these ports or counters, with all other behaviour identical.

Verification (NumPhys=2, AxiDataWidth=128: W=32, R=4)
REQ-029 SHALL test: words 0x11111111, 0x22222222, 0x33333333, 0x44444444 (last on the 4th) with ready_i=1 -> one beat data_o=0x44444444_33333333_22222222_11111111, words_o=4, last_o=1, one cycle after the 4th word.
REQ-030 SHALL test: words 0xAAAAAAAA, 0xBBBBBBBB with last on the 2nd -> data_o=0x0..0_BBBBBBBB_AAAAAAAA, words_o=2, last_o=1.
REQ-031 SHALL test: ready_i=0 with 8 words streamed -> the 4 words of the first beat plus 3 more are accepted, rx_ready_o goes low at the 8th word, and raising ready_i gives two beats back-to-back with no bubble.
REQ-032 SHALL test: rx_error_i=1 on word 1 only of a 4-word beat -> error_o=1 for that beat and error_o=0 for the next beat.
REQ-033 SHALL test: 2 words accepted then clear_i, then 4 new words -> only the new beat appears, words_o=4, with no stale data.
REQ-034 SHALL test: rst_i pulsed mid-beat with valid_o high -> valid_o=0 immediately, and the stats counters read 0 when HYPERBUS_RX_PACKER_STATS_EN is defined.
